// File: rtl/or_way_selftest_pkg.sv
// Shared definitions for the OR-reduction built-in self test: FSM state
// encodings and the vector-count / width derivations.
package or_way_selftest_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // One all-zeros vector, one walking-one per input bit, one all-ones vector.
    function automatic int calc_nv(input int width);
        return width + 2;
    endfunction

    // Mismatch counter must reach NV itself, hence NV+1 codes.
    function automatic int calc_cw(input int width);
        return $clog2(calc_nv(width) + 1);
    endfunction

    function automatic int calc_iw(input int width);
        return $clog2(calc_nv(width));
    endfunction

    function automatic int calc_dw(input int dwell);
        return (dwell > 1) ? $clog2(dwell) : 1;
    endfunction

endpackage

// File: rtl/or_way_selftest_or_nway.sv
// Purely combinational N-input OR gate; the unit exercised by the self test.
module or_nway #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in,
    output logic             out
);

    assign out = |in;

endmodule

// File: rtl/or_way_selftest.sv
// Self-test sequencer: walks a generated vector set through one or_nway
// instance, counts mismatches and reports pass/fail on status outputs and LEDs.
module or_way_selftest
    import or_way_selftest_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DWELL = 1,
    localparam int NV    = calc_nv(WIDTH),
    localparam int CW    = calc_cw(WIDTH),
    localparam int IW    = calc_iw(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          inject,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [CW-1:0] fail_count,
    output logic [IW-1:0] first_fail,
    output logic [3:0]    led
);

    localparam int             DW  = calc_dw(DWELL);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e        state_q;
    logic [IW-1:0] idx_q;
    logic [DW-1:0] dwell_q;
    logic [CW-1:0] fail_count_q;
    logic [IW-1:0] first_fail_q;
    logic          seen_q;
    logic          pass_q;

    logic [WIDTH-1:0] test_vec;
    logic             dut_out;
    logic             exp_bit;
    logic             mismatch;
    logic             last_idx;

    // Vector is forced to zero outside APPLY/CHECK so the DUT sees no activity when idle.
    always_comb begin
        test_vec = '0;
        if (state_q == ST_APPLY || state_q == ST_CHECK) begin
            if (idx_q == IW'(NV - 1)) begin
                test_vec = '1;
            end else if (idx_q != '0) begin
                test_vec = ONE << (idx_q - IW'(1));
            end
        end
    end

    assign exp_bit  = (idx_q != '0);
    assign mismatch = ((dut_out ^ inject) != exp_bit);
    assign last_idx = (idx_q == IW'(NV - 1));

    or_nway #(
        .WIDTH (WIDTH)
    ) u_or_nway (
        .in  (test_vec),
        .out (dut_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            dwell_q      <= '0;
            fail_count_q <= '0;
            first_fail_q <= '0;
            seen_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q      <= ST_APPLY;
                        idx_q        <= '0;
                        dwell_q      <= '0;
                        fail_count_q <= '0;
                        first_fail_q <= '0;
                        seen_q       <= 1'b0;
                        pass_q       <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    if (dwell_q == DW'(DWELL - 1)) begin
                        dwell_q <= '0;
                        state_q <= ST_CHECK;
                    end else begin
                        dwell_q <= dwell_q + DW'(1);
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        if (fail_count_q != CW'(NV)) begin
                            fail_count_q <= fail_count_q + CW'(1);
                        end
                        if (!seen_q) begin
                            seen_q       <= 1'b1;
                            first_fail_q <= idx_q;
                        end
                    end
                    if (last_idx) begin
                        state_q <= ST_DONE;
                        pass_q  <= (fail_count_q == '0) && !mismatch;
                    end else begin
                        idx_q   <= idx_q + IW'(1);
                        state_q <= ST_APPLY;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy       = (state_q == ST_APPLY) || (state_q == ST_CHECK);
    assign done       = (state_q == ST_DONE);
    assign pass       = pass_q;
    assign fail_count = fail_count_q;
    assign first_fail = first_fail_q;
    assign led        = {done & ~pass_q, pass_q, done, busy};

endmodule

// File: tb/tb_or_way_selftest.sv
// Bench for or_way_selftest: three instances (8/1, 4/3, 2/1 for WIDTH/DWELL)
// driven through table-driven runs and hand-written corner-case sequences.
module tb_or_way_selftest;

    localparam int EW = 29;

    logic       clk = 1'b0;
    logic [2:0] rst;
    logic [2:0] st;
    logic [2:0] inj;

    logic       busy_w [3];
    logic       done_w [3];
    logic       pass_w [3];
    logic [7:0] fc_w   [3];
    logic [7:0] ff_w   [3];
    logic [3:0] led_w  [3];

    logic [3:0] fc8, ff8;
    logic [2:0] fc4, ff4;
    logic [2:0] fc2;
    logic [1:0] ff2;

    int n_tests = 0;
    int n_fail  = 0;
    int run_len   [3];
    logic prev_busy [3];

    logic [EW-1:0] exp_q[$];

    typedef struct {
        int       k;
        bit       inj;
        int       busy;
        bit       pass;
        int       fc;
        int       ff;
        logic [3:0] led;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    or_way_selftest #(.WIDTH(8), .DWELL(1)) u_d8 (
        .clk(clk), .reset(rst[0]), .start(st[0]), .inject(inj[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .fail_count(fc8), .first_fail(ff8), .led(led_w[0])
    );

    or_way_selftest #(.WIDTH(4), .DWELL(3)) u_d4 (
        .clk(clk), .reset(rst[1]), .start(st[1]), .inject(inj[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .fail_count(fc4), .first_fail(ff4), .led(led_w[1])
    );

    or_way_selftest #(.WIDTH(2), .DWELL(1)) u_d2 (
        .clk(clk), .reset(rst[2]), .start(st[2]), .inject(inj[2]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .fail_count(fc2), .first_fail(ff2), .led(led_w[2])
    );

    assign fc_w[0] = {4'b0, fc8};
    assign ff_w[0] = {4'b0, ff8};
    assign fc_w[1] = {5'b0, fc4};
    assign ff_w[1] = {5'b0, ff4};
    assign fc_w[2] = {5'b0, fc2};
    assign ff_w[2] = {6'b0, ff2};

    // Length of the most recent contiguous busy interval per instance.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (busy_w[k]) run_len[k] = prev_busy[k] ? run_len[k] + 1 : 1;
            prev_busy[k] = busy_w[k];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] pack(input int busy, input bit pass, input int fc,
                                           input int ff, input logic [3:0] led);
        return {busy[7:0], pass, fc[7:0], ff[7:0], led};
    endfunction

    task automatic pulse_start(input int k);
        @(negedge clk);
        st[k] = 1'b1;
        @(negedge clk);
        st[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, output bit ok, output bit busy_before);
        int n = 0;
        ok = 1'b0;
        busy_before = 1'b0;
        while (n < 2000) begin
            if (done_w[k]) begin
                ok = 1'b1;
                break;
            end
            busy_before = busy_w[k];
            @(negedge clk);
            n++;
        end
    endtask

    task automatic finish_run(input int k, input string name);
        bit ok, bb;
        logic [EW-1:0] e;
        wait_done(k, ok, bb);
        chk({name, " done_reached"}, ok, 1);
        e = exp_q.pop_front();
        chk({name, " busy_then_done"}, bb, 1);
        chk({name, " busy_cycles"}, run_len[k], int'(e[28:21]));
        chk({name, " pass"}, pass_w[k], int'(e[20]));
        chk({name, " fail_count"}, fc_w[k], int'(e[19:12]));
        chk({name, " first_fail"}, ff_w[k], int'(e[11:4]));
        chk({name, " led"}, led_w[k], int'(e[3:0]));
    endtask

    task automatic check_idle(input int k, input string name);
        chk({name, " busy"}, busy_w[k], 0);
        chk({name, " done"}, done_w[k], 0);
        chk({name, " pass"}, pass_w[k], 0);
        chk({name, " fail_count"}, fc_w[k], 0);
        chk({name, " first_fail"}, ff_w[k], 0);
        chk({name, " led"}, led_w[k], 0);
    endtask

    // Inject exactly during the CHECK cycle of vector idx; period = DWELL+1.
    task automatic run_inject_at(input int k, input int idx, input int period,
                                 input int busy, input string name);
        exp_q.push_back(pack(busy, 1'b0, 1, idx, 4'b1010));
        pulse_start(k);
        repeat (idx * period + period - 1) @(negedge clk);
        inj[k] = 1'b1;
        @(negedge clk);
        inj[k] = 1'b0;
        finish_run(k, name);
    endtask

    initial begin
        vecs[0] = '{k: 0, inj: 1'b0, busy: 20, pass: 1'b1, fc: 0,  ff: 0, led: 4'b0110};
        vecs[1] = '{k: 0, inj: 1'b1, busy: 20, pass: 1'b0, fc: 10, ff: 0, led: 4'b1010};
        vecs[2] = '{k: 1, inj: 1'b0, busy: 24, pass: 1'b1, fc: 0,  ff: 0, led: 4'b0110};
        vecs[3] = '{k: 1, inj: 1'b1, busy: 24, pass: 1'b0, fc: 6,  ff: 0, led: 4'b1010};
        vecs[4] = '{k: 2, inj: 1'b0, busy: 8,  pass: 1'b1, fc: 0,  ff: 0, led: 4'b0110};
        vecs[5] = '{k: 2, inj: 1'b1, busy: 8,  pass: 1'b0, fc: 4,  ff: 0, led: 4'b1010};

        for (int k = 0; k < 3; k++) begin
            run_len[k]   = 0;
            prev_busy[k] = 1'b0;
        end

        // Clock/reset
        rst = 3'b111;
        st  = 3'b000;
        inj = 3'b000;
        repeat (3) @(negedge clk);
        rst = 3'b000;
        @(negedge clk);
        check_idle(0, "reset_d8");
        check_idle(1, "reset_d4");
        check_idle(2, "reset_d2");

        // Table-driven full runs
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            inj[vecs[i].k] = vecs[i].inj;
            exp_q.push_back(pack(vecs[i].busy, vecs[i].pass, vecs[i].fc, vecs[i].ff, vecs[i].led));
            pulse_start(vecs[i].k);
            finish_run(vecs[i].k, $sformatf("vec%0d", i));
            inj[vecs[i].k] = 1'b0;
        end

        // Single-CHECK injection
        run_inject_at(1, 3, 4, 24, "inj_idx3_d4");
        run_inject_at(0, 8, 2, 20, "inj_idx8_d8");

        // Start while busy is ignored; DONE holds with start low
        exp_q.push_back(pack(20, 1'b1, 0, 0, 4'b0110));
        pulse_start(0);
        repeat (5) @(negedge clk);
        pulse_start(0);
        finish_run(0, "start_ignored");
        repeat (6) @(negedge clk);
        chk("done_hold done", done_w[0], 1);
        chk("done_hold pass", pass_w[0], 1);
        chk("done_hold fail_count", fc_w[0], 0);

        // Reset mid-run aborts, then a clean rerun
        pulse_start(0);
        repeat (4) @(negedge clk);
        inj[0] = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrun fail_count", fc_w[0], 2);
        chk("midrun first_fail", ff_w[0], 2);
        chk("midrun busy", busy_w[0], 1);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        inj[0] = 1'b0;
        check_idle(0, "abort");
        exp_q.push_back(pack(20, 1'b1, 0, 0, 4'b0110));
        pulse_start(0);
        finish_run(0, "rerun");

        // Reset wins over start at the same edge
        @(negedge clk);
        rst[2] = 1'b1;
        st[2]  = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        st[2]  = 1'b0;
        check_idle(2, "rst_prio");

        // Start held high: one run, then immediate restart from DONE
        exp_q.push_back(pack(24, 1'b1, 0, 0, 4'b0110));
        @(negedge clk);
        st[1] = 1'b1;
        @(negedge clk);
        finish_run(1, "held_start");
        @(negedge clk);
        chk("held_restart busy", busy_w[1], 1);
        chk("held_restart done", done_w[1], 0);
        st[1] = 1'b0;
        exp_q.push_back(pack(24, 1'b1, 0, 0, 4'b0110));
        finish_run(1, "held_second");

        chk("scoreboard empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
